// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset vector start, sequential stepping, flush/branch redirects
// and a one-deep pending branch target held while fetch is stalled. Optional macro: PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int                  ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = 32'hBFC00000,
    parameter int                  PC_STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_ds_o,
    output logic              ce,
    output logic              redirect_pending_o
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              adel_o
`endif
);

    // state | meaning
    // IDLE  | in or just out of reset, fetch disabled (ce=0)
    // RUN   | fetching, pc advances or redirects each edge
    // HOLD  | stalled with a branch target waiting in pend_tgt
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_tgt, pend_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            pend_tgt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_tgt <= pend_nxt;
        end
    end

    // Priority: flush > branch > stall > pending release / sequential step.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_tgt;
        case (state)
            IDLE: state_nxt = RUN;
            RUN, HOLD: begin
                if (flush_i) begin
                    pc_nxt    = flush_pc_i;
                    pend_nxt  = '0;
                    state_nxt = RUN;
                end else if (branch_flag_i && !stall) begin
                    pc_nxt    = branch_target_address_i;
                    pend_nxt  = '0;
                    state_nxt = RUN;
                end else if (branch_flag_i) begin
                    pend_nxt  = branch_target_address_i;
                    state_nxt = HOLD;
                end else if (!stall) begin
                    if (state == HOLD) begin
                        pc_nxt    = pend_tgt;
                        pend_nxt  = '0;
                        state_nxt = RUN;
                    end else begin
                        pc_nxt = pc + STEP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ce                 = 1'b0;
        redirect_pending_o = 1'b0;
        case (state)
            RUN:  ce = 1'b1;
            HOLD: begin
                ce                 = 1'b1;
                redirect_pending_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_ds_o = pc + STEP;

`ifdef PC_ALIGN_CHECK_EN
    // Only redirect loads are reported, so a misaligned target flags once rather than on every step.
    logic redir_load;

    always_comb begin
        redir_load = 1'b0;
        if (state != IDLE) begin
            redir_load = flush_i
                       || (branch_flag_i && !stall)
                       || (state == HOLD && !stall && !branch_flag_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            adel_o <= 1'b0;
        end else begin
            adel_o <= redir_load && (pc_nxt[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Randomized and directed bench for pc_gen against an arithmetic reference of the fetch rules.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [31:0] pc, pc_ds_o;
    logic        ce, redirect_pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        adel_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .flush_pc_i              (flush_pc_i),
        .pc                      (pc),
        .pc_ds_o                 (pc_ds_o),
        .ce                      (ce),
        .redirect_pending_o      (redirect_pending_o)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .adel_o                  (adel_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference: fetching flag, optional waiting target, current address.
    bit          m_valid = 0;
    bit          m_fetching = 0;
    bit          m_has_pend = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_pc = '0;
    bit          m_adel = 0;

    always @(posedge clk) begin
        m_adel = 0;
        if (!rst) begin
            m_valid    = 1;
            m_fetching = 0;
            m_has_pend = 0;
            m_pc       = RV;
        end else if (!m_fetching) begin
            m_fetching = 1;
        end else if (flush_i) begin
            m_pc = flush_pc_i;  m_has_pend = 0;  m_adel = (m_pc % 4) != 0;
        end else if (branch_flag_i && !stall) begin
            m_pc = branch_target_address_i;  m_has_pend = 0;  m_adel = (m_pc % 4) != 0;
        end else if (branch_flag_i) begin
            m_has_pend = 1;  m_pend = branch_target_address_i;
        end else if (!stall) begin
            if (m_has_pend) begin
                m_pc = m_pend;  m_has_pend = 0;  m_adel = (m_pc % 4) != 0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", pc, m_pc);
            chk("model_pc_ds", pc_ds_o, m_pc + 32'd4);
            chk("model_ce", {31'd0, ce}, {31'd0, m_fetching});
            chk("model_pending", {31'd0, redirect_pending_o}, {31'd0, m_has_pend});
`ifdef PC_ALIGN_CHECK_EN
            chk("model_adel", {31'd0, adel_o}, {31'd0, m_adel});
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0;  branch_flag_i = 0;  flush_i = 0;
    endtask

    initial begin
        // Reset release
        step(3);
        chk("rst_pc", pc, 32'hBFC00000);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_pc_ds", pc_ds_o, 32'hBFC00004);
        rst = 1;
        step(1);
        chk("rel_pc0", pc, 32'hBFC00000);
        chk("rel_ce", {31'd0, ce}, 32'd1);
        step(1);  chk("rel_pc1", pc, 32'hBFC00004);
        step(1);  chk("rel_pc2", pc, 32'hBFC00008);
        step(2);  chk("seq_pc", pc, 32'hBFC00010);

        // Stalled branch
        stall = 1;  branch_flag_i = 1;  branch_target_address_i = 32'h80001000;
        step(1);
        branch_flag_i = 0;
        chk("hold_pc", pc, 32'hBFC00010);
        chk("hold_pend", {31'd0, redirect_pending_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("hold_pc_k", pc, 32'hBFC00010);
            chk("hold_pend_k", {31'd0, redirect_pending_o}, 32'd1);
        end
        stall = 0;
        step(1);
        chk("take_pc", pc, 32'h80001000);
        chk("take_pend", {31'd0, redirect_pending_o}, 32'd0);
        step(1);  chk("take_seq", pc, 32'h80001004);

        // Flush beats branch and stall
        flush_i = 1;  flush_pc_i = 32'hBFC00380;
        branch_flag_i = 1;  branch_target_address_i = 32'h11111110;  stall = 1;
        step(1);
        idle_inputs();
        chk("flush_pc", pc, 32'hBFC00380);
        chk("flush_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Wrap-around
        branch_flag_i = 1;  branch_target_address_i = 32'hFFFFFFFC;
        step(1);
        branch_flag_i = 0;
        chk("wrap_pre", pc, 32'hFFFFFFFC);
        chk("wrap_ds", pc_ds_o, 32'h00000000);
        step(1);  chk("wrap_pc", pc, 32'h00000000);

        // Reset mid-HOLD
        stall = 1;  branch_flag_i = 1;  branch_target_address_i = 32'h12345678;
        step(1);
        branch_flag_i = 0;
        chk("rh_pend", {31'd0, redirect_pending_o}, 32'd1);
        rst = 0;
        step(1);
        chk("rh_pc", pc, RV);
        chk("rh_ce", {31'd0, ce}, 32'd0);
        chk("rh_pend0", {31'd0, redirect_pending_o}, 32'd0);
        rst = 1;  stall = 0;
        step(1);  chk("rh_rel0", pc, RV);
        step(1);  chk("rh_rel1", pc, RV + 32'd4);

`ifdef PC_ALIGN_CHECK_EN
        branch_flag_i = 1;  branch_target_address_i = 32'h80000002;
        step(1);
        branch_flag_i = 0;
        chk("adel_pc", pc, 32'h80000002);
        chk("adel_set", {31'd0, adel_o}, 32'd1);
        step(1);
        chk("adel_pc2", pc, 32'h80000006);
        chk("adel_clr", {31'd0, adel_o}, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) >= 2);
            stall         = ($urandom_range(0, 99) < 35);
            branch_flag_i = ($urandom_range(0, 99) < 20);
            flush_i       = ($urandom_range(0, 99) < 6);
            branch_target_address_i = $urandom;
            flush_pc_i    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                branch_target_address_i[1:0] = 2'b00;
                flush_pc_i[1:0] = 2'b00;
            end
            step(1);
        end
        idle_inputs();
        rst = 1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
